panel_control: RTL and testbench
================================

# panel_control

Front-panel controller for the PDP-8 core: converts raw console keys into run/halt control for the instruction sequencer and owns the memory bus while the CPU is halted. It performs LOAD ADDRESS, DEPOSIT and EXAMINE with auto-increment, and START, CONTINUE, STOP and SINGLE INSTRUCTION. It sits between the console switch inputs and the sequencer/memory/PC datapath.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer flops per key input (≥2)
- MEM_LAT, 1, cycles from MEM_RE to valid MEM_RDATA (≥1)

Ports:
- SYSCLK  in  1  system clock; all state changes on rising edge
- RESET_N  in  1  reset; one clock, reset asynchronous and active-low
- KEY_START, KEY_CONT, KEY_STOP, KEY_SSTEP, KEY_LOADADDR, KEY_DEP, KEY_EXAM  in  1 each  raw active-high keys, asynchronous to SYSCLK
- SW  in  12  switch register
- INST_DONE  in  1  one-cycle pulse from sequencer at end of each instruction
- HLT_INST  in  1  one-cycle pulse: HLT instruction executed
- MEM_RDATA  in  12  memory read data
- RUN  out  1  level, high while CPU is allowed to execute
- HALT  out  1  one-cycle pulse halting the sequencer at the instruction boundary
- CPU_CLEAR  out  1  one-cycle pulse clearing AC/L
- PC_LOAD  out  1  one-cycle pulse loading PC from PC_DATA
- PC_DATA  out  12  equals PANEL_ADDR
- PANEL_BUS  out  1  panel owns memory bus
- MEM_ADDR  out  12  equals PANEL_ADDR
- MEM_WDATA  out  12  equals SW
- MEM_WE, MEM_RE  out  1 each  one-cycle strobes
- PANEL_ADDR  out  12  panel address register (MA lamps)
- MB_DISP  out  12  last examined/deposited word (MB lamps)
- RUNNING  out  1  lamp; high in RUNNING and STEPPING

## Operation
- Each key: SYNC_STAGES-flop synchronizer, then a rising-edge detector producing a one-cycle key event. Holding a key produces exactly one event.
- Simultaneous events resolve by priority: STOP > START > CONT > SSTEP > LOADADDR > DEP > EXAM. Lower-priority events in the same cycle are dropped.
- States:
  - HALTED: PANEL_BUS=1.
    - START → CLR.
    - CONT → RUNNING.
    - SSTEP → STEPPING.
    - LOADADDR: PANEL_ADDR<=SW; stay.
    - DEP → DEP_WR.
    - EXAM → EXAM_RD.
    - STOP ignored.
  - CLR: CPU_CLEAR=1 → LDPC.
  - LDPC: PC_LOAD=1 → RUNNING.
  - RUNNING: RUN=1.
    - STOP or HLT_INST → STOPPING. If INST_DONE arrives in the same cycle, go directly to HALTED with HALT=1.
  - STOPPING: RUN=1; on INST_DONE, HALT=1 and RUN=0 in that cycle → HALTED.
  - STEPPING: RUN=1; on INST_DONE, HALT=1 → HALTED. STOP is redundant here and ignored.
  - DEP_WR: MEM_WE=1; MB_DISP<=SW; PANEL_ADDR<=PANEL_ADDR+1 → HALTED.
  - EXAM_RD: MEM_RE=1 → EXAM_WAIT.
  - EXAM_WAIT: wait MEM_LAT cycles; MB_DISP<=MEM_RDATA; PANEL_ADDR<=PANEL_ADDR+1 → HALTED.
- Key events arriving outside HALTED (other than STOP in RUNNING) are dropped, not queued.
- PANEL_BUS=1 in HALTED, DEP_WR, EXAM_RD, EXAM_WAIT; 0 otherwise. MEM_WE/MEM_RE are never asserted with PANEL_BUS=0.
- PANEL_ADDR is 12-bit modulo: 7777₈+1 = 0000₈. MEM_ADDR is the pre-increment value during the strobe.
- HLT_INST or INST_DONE in HALTED/DEP/EXAM/CLR/LDPC is ignored.

## Timing
- Reset (asynchronous assert, synchronous release): state HALTED, PANEL_ADDR=0, MB_DISP=0, all strobes/RUN/HALT/RUNNING=0, PANEL_BUS=1, synchronizers and edge detectors cleared. A key held through reset release produces no event.
- Key latency: key rises before edge k → event in cycle k+SYNC_STAGES → state action the following cycle.
- START: CPU_CLEAR at N, PC_LOAD at N+1, RUN high from N+2.
- CONT/SSTEP: RUN high the cycle after the event.
- HALT pulse coincides with the INST_DONE cycle; RUN is low in that same cycle and thereafter.
- DEP: one cycle of MEM_WE; PANEL_ADDR increment visible the next cycle.
- EXAM: MEM_RE at cycle E; MB_DISP valid at E+MEM_LAT+1.
- Reset mid-operation: immediate return to reset values; a pending stop is discarded.

## Test plan
- Reset, SW=0200₈, LOADADDR, SW=7402₈, DEP → one MEM_WE, MEM_ADDR=0200₈, MEM_WDATA=7402₈, PANEL_ADDR=0201₈, MB_DISP=7402₈.
- PANEL_ADDR=7777₈, EXAM with MEM_RDATA=1234₈, MEM_LAT=1 → MB_DISP=1234₈ at E+2, PANEL_ADDR=0000₈.
- LOADADDR 0200₈, START → CPU_CLEAR, then PC_LOAD with PC_DATA=0200₈, then RUN=1/RUNNING=1; STOP mid-instruction → HALT only on next INST_DONE, then PANEL_BUS=1.
- SSTEP → RUN for exactly one instruction; HALT on first INST_DONE; three INST_DONE pulses after three SSTEPs give three HALTs.
- RUNNING, HLT_INST → halts at INST_DONE; DEP/EXAM pressed while running → no MEM_WE/MEM_RE, PANEL_ADDR unchanged.
- START and DEP asserted in the same cycle → START wins, no MEM_WE; key held 1000 cycles → single event; RESET_N pulled low in STOPPING → all outputs at reset values immediately.

Source files
------------

// File: rtl/panel_control.sv
// PDP-8 front-panel controller: debounced key events drive run/halt control of the
// sequencer, and the panel owns the memory bus for LOAD ADDRESS / DEPOSIT / EXAMINE.
module panel_control #(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_LAT     = 1
) (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        KEY_START,
  input  logic        KEY_CONT,
  input  logic        KEY_STOP,
  input  logic        KEY_SSTEP,
  input  logic        KEY_LOADADDR,
  input  logic        KEY_DEP,
  input  logic        KEY_EXAM,
  input  logic [11:0] SW,
  input  logic        INST_DONE,
  input  logic        HLT_INST,
  input  logic [11:0] MEM_RDATA,
  output logic        RUN,
  output logic        HALT,
  output logic        CPU_CLEAR,
  output logic        PC_LOAD,
  output logic [11:0] PC_DATA,
  output logic        PANEL_BUS,
  output logic [11:0] MEM_ADDR,
  output logic [11:0] MEM_WDATA,
  output logic        MEM_WE,
  output logic        MEM_RE,
  output logic [11:0] PANEL_ADDR,
  output logic [11:0] MB_DISP,
  output logic        RUNNING
);

  typedef enum logic [3:0] {
    S_HALTED, S_CLR, S_LDPC, S_RUNNING, S_STOPPING, S_STEPPING,
    S_DEP_WR, S_EXAM_RD, S_EXAM_WAIT
  } state_t;

  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  // Bit order doubles as priority: bit 0 (STOP) highest, bit 6 (EXAM) lowest.
  logic [6:0] key_raw;
  assign key_raw = {KEY_EXAM, KEY_DEP, KEY_LOADADDR, KEY_SSTEP, KEY_CONT, KEY_START, KEY_STOP};

  logic [SYNC_STAGES-1:0][6:0] sync_q;
  logic [6:0]                  prev_q;
  logic [WW-1:0]               warm_q;
  logic                        armed;
  logic [6:0]                  evt;
  logic [6:0]                  ev;

  // Events stay masked until the edge detector has seen a settled synchronizer
  // output, so a key held across reset release never looks like a fresh press.
  assign armed = (warm_q == WW'(SYNC_STAGES + 1));
  assign evt   = armed ? (sync_q[SYNC_STAGES-1] & ~prev_q) : 7'd0;
  assign ev    = evt & (~evt + 7'd1);

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!armed) warm_q <= warm_q + 1'b1;
    end
  end

  state_t        state_q;
  logic [11:0]   addr_q;
  logic [11:0]   mb_q;
  logic [LW-1:0] lat_q;
  logic          clr_q, pcld_q, we_q, re_q, run_q, bus_q;

  // HALT must land in the INST_DONE cycle itself, so it is decoded from the input.
  always_comb begin
    HALT = 1'b0;
    if (INST_DONE) begin
      case (state_q)
        S_RUNNING:              HALT = ev[0] | HLT_INST;
        S_STOPPING, S_STEPPING: HALT = 1'b1;
        default:                HALT = 1'b0;
      endcase
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_HALTED;
      addr_q  <= '0;
      mb_q    <= '0;
      lat_q   <= '0;
      clr_q   <= 1'b0;
      pcld_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      run_q   <= 1'b0;
      bus_q   <= 1'b1;
    end else begin
      clr_q  <= 1'b0;
      pcld_q <= 1'b0;
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      case (state_q)
        S_HALTED: begin
          if (ev[1]) begin
            state_q <= S_CLR;
            clr_q   <= 1'b1;
            bus_q   <= 1'b0;
          end else if (ev[2]) begin
            state_q <= S_RUNNING;
            run_q   <= 1'b1;
            bus_q   <= 1'b0;
          end else if (ev[3]) begin
            state_q <= S_STEPPING;
            run_q   <= 1'b1;
            bus_q   <= 1'b0;
          end else if (ev[4]) begin
            addr_q  <= SW;
          end else if (ev[5]) begin
            state_q <= S_DEP_WR;
            we_q    <= 1'b1;
          end else if (ev[6]) begin
            state_q <= S_EXAM_RD;
            re_q    <= 1'b1;
          end
        end
        S_CLR: begin
          state_q <= S_LDPC;
          pcld_q  <= 1'b1;
        end
        S_LDPC: begin
          state_q <= S_RUNNING;
          run_q   <= 1'b1;
        end
        S_RUNNING: begin
          if (ev[0] | HLT_INST) begin
            if (INST_DONE) begin
              state_q <= S_HALTED;
              run_q   <= 1'b0;
              bus_q   <= 1'b1;
            end else begin
              state_q <= S_STOPPING;
            end
          end
        end
        S_STOPPING, S_STEPPING: begin
          if (INST_DONE) begin
            state_q <= S_HALTED;
            run_q   <= 1'b0;
            bus_q   <= 1'b1;
          end
        end
        S_DEP_WR: begin
          mb_q    <= SW;
          addr_q  <= addr_q + 12'd1;
          state_q <= S_HALTED;
        end
        S_EXAM_RD: begin
          lat_q   <= LW'(MEM_LAT - 1);
          state_q <= S_EXAM_WAIT;
        end
        S_EXAM_WAIT: begin
          if (lat_q == '0) begin
            mb_q    <= MEM_RDATA;
            addr_q  <= addr_q + 12'd1;
            state_q <= S_HALTED;
          end else begin
            lat_q   <= lat_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_HALTED;
          run_q   <= 1'b0;
          bus_q   <= 1'b1;
        end
      endcase
    end
  end

  assign RUN        = run_q & ~HALT;
  assign RUNNING    = run_q;
  assign CPU_CLEAR  = clr_q;
  assign PC_LOAD    = pcld_q;
  assign MEM_WE     = we_q;
  assign MEM_RE     = re_q;
  assign PANEL_BUS  = bus_q;
  assign PANEL_ADDR = addr_q;
  assign PC_DATA    = addr_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_WDATA  = SW;
  assign MB_DISP    = mb_q;

endmodule

// File: tb/tb_panel_control.sv
// Directed bench for panel_control: console key sequences with hand-computed lamp,
// strobe and run/halt expectations.
module tb_panel_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  keys = '0;  // 0 STOP,1 START,2 CONT,3 SSTEP,4 LOADADDR,5 DEP,6 EXAM
  logic [11:0] sw = '0;
  logic        inst_done = 1'b0;
  logic        hlt_inst = 1'b0;
  logic [11:0] mem_rdata = '0;

  logic        run, halt, cpu_clear, pc_load, panel_bus, mem_we, mem_re, running;
  logic [11:0] pc_data, mem_addr, mem_wdata, panel_addr, mb_disp;

  int errors = 0;
  int checks = 0;

  panel_control #(.SYNC_STAGES(2), .MEM_LAT(1)) dut (
    .SYSCLK(clk), .RESET_N(rst_n),
    .KEY_START(keys[1]), .KEY_CONT(keys[2]), .KEY_STOP(keys[0]), .KEY_SSTEP(keys[3]),
    .KEY_LOADADDR(keys[4]), .KEY_DEP(keys[5]), .KEY_EXAM(keys[6]),
    .SW(sw), .INST_DONE(inst_done), .HLT_INST(hlt_inst), .MEM_RDATA(mem_rdata),
    .RUN(run), .HALT(halt), .CPU_CLEAR(cpu_clear), .PC_LOAD(pc_load), .PC_DATA(pc_data),
    .PANEL_BUS(panel_bus), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_WE(mem_we), .MEM_RE(mem_re), .PANEL_ADDR(panel_addr), .MB_DISP(mb_disp),
    .RUNNING(running)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the falling edge.
  int cyc = 0, we_cnt = 0, re_cnt = 0, clr_cnt = 0, pcld_cnt = 0, halt_cnt = 0;
  int halt_bad = 0, bus_viol = 0;
  int re_cyc = 0, clr_cyc = 0, pcld_cyc = 0, run_rise_cyc = 0, mb_chg_cyc = 0;
  logic [11:0] we_addr = '0, we_data = '0, pcld_data = '0, mb_prev = '0;
  logic        run_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_we) begin
      we_cnt = we_cnt + 1; we_addr = mem_addr; we_data = mem_wdata;
      if (!panel_bus) bus_viol = bus_viol + 1;
    end
    if (mem_re) begin
      re_cnt = re_cnt + 1; re_cyc = cyc;
      if (!panel_bus) bus_viol = bus_viol + 1;
    end
    if (cpu_clear) begin clr_cnt = clr_cnt + 1; clr_cyc = cyc; end
    if (pc_load) begin pcld_cnt = pcld_cnt + 1; pcld_cyc = cyc; pcld_data = pc_data; end
    if (halt) begin
      halt_cnt = halt_cnt + 1;
      if (!inst_done || run) halt_bad = halt_bad + 1;
    end
    if (run && !run_prev) run_rise_cyc = cyc;
    run_prev = run;
    if (mb_disp != mb_prev) mb_chg_cyc = cyc;
    mb_prev = mb_disp;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0o, expected %0o", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int idx, input int hold);
    keys[idx] = 1'b1;
    tick(hold);
    keys[idx] = 1'b0;
    tick(4);
  endtask

  task automatic pulse_done();
    inst_done = 1'b1;
    tick(1);
    inst_done = 1'b0;
    tick(2);
  endtask

  int w0, r0, c0, p0, h0;
  logic [11:0] a0;

  initial begin
    tick(3);
    chk("rst_run", {31'd0, run}, 0);
    chk("rst_running", {31'd0, running}, 0);
    chk("rst_bus", {31'd0, panel_bus}, 1);
    chk("rst_addr", {20'd0, panel_addr}, 0);
    chk("rst_mb", {20'd0, mb_disp}, 0);
    chk("rst_strobes", {28'd0, mem_we, mem_re, cpu_clear, pc_load}, 0);
    rst_n = 1'b1;
    tick(5);

    // LOAD ADDRESS then DEPOSIT
    sw = 12'o0200; press(4, 6);
    chk("loadaddr", {20'd0, panel_addr}, 32'o0200);
    sw = 12'o7402; w0 = we_cnt; press(5, 6);
    chk("dep_we_count", we_cnt - w0, 1);
    chk("dep_mem_addr", {20'd0, we_addr}, 32'o0200);
    chk("dep_mem_wdata", {20'd0, we_data}, 32'o7402);
    chk("dep_addr_inc", {20'd0, panel_addr}, 32'o0201);
    chk("dep_mb", {20'd0, mb_disp}, 32'o7402);

    // EXAMINE at the top of memory wraps the address
    sw = 12'o7777; press(4, 6);
    mem_rdata = 12'o1234; r0 = re_cnt; press(6, 6);
    chk("exam_re_count", re_cnt - r0, 1);
    chk("exam_mb", {20'd0, mb_disp}, 32'o1234);
    chk("exam_latency", mb_chg_cyc - re_cyc, 2);
    chk("exam_addr_wrap", {20'd0, panel_addr}, 0);

    // START sequence then STOP mid-instruction
    sw = 12'o0200; press(4, 6);
    c0 = clr_cnt; p0 = pcld_cnt; h0 = halt_cnt;
    press(1, 6);
    chk("start_clear", clr_cnt - c0, 1);
    chk("start_pcload", pcld_cnt - p0, 1);
    chk("start_pcload_timing", pcld_cyc - clr_cyc, 1);
    chk("start_pc_data", {20'd0, pcld_data}, 32'o0200);
    chk("start_run_timing", run_rise_cyc - pcld_cyc, 1);
    chk("start_run", {30'd0, run, running}, 3);
    chk("start_bus", {31'd0, panel_bus}, 0);
    press(0, 6);
    chk("stop_still_run", {31'd0, run}, 1);
    chk("stop_no_halt_yet", halt_cnt - h0, 0);
    pulse_done();
    chk("stop_halt", halt_cnt - h0, 1);
    chk("stop_halt_shape", halt_bad, 0);
    chk("stop_halted", {29'd0, run, running, panel_bus}, 1);

    // SINGLE INSTRUCTION three times
    h0 = halt_cnt;
    for (int i = 0; i < 3; i++) begin
      press(3, 6);
      chk("sstep_run", {31'd0, run}, 1);
      pulse_done();
      chk("sstep_halted", {31'd0, run}, 0);
    end
    chk("sstep_halts", halt_cnt - h0, 3);
    pulse_done();
    chk("halted_ignores_done", halt_cnt - h0, 3);

    // CONTINUE; DEP/EXAM dropped while running; HLT instruction halts at boundary
    a0 = panel_addr; w0 = we_cnt; r0 = re_cnt; h0 = halt_cnt;
    press(2, 6);
    chk("cont_run", {31'd0, run}, 1);
    press(5, 6);
    press(6, 6);
    chk("run_no_we", we_cnt - w0, 0);
    chk("run_no_re", re_cnt - r0, 0);
    chk("run_addr_same", {20'd0, panel_addr}, {20'd0, a0});
    hlt_inst = 1'b1; tick(1); hlt_inst = 1'b0; tick(2);
    chk("hlt_still_run", {31'd0, run}, 1);
    pulse_done();
    chk("hlt_halt", halt_cnt - h0, 1);
    chk("hlt_halted", {31'd0, run}, 0);

    // START and DEP together: START wins
    w0 = we_cnt; c0 = clr_cnt;
    keys[1] = 1'b1; keys[5] = 1'b1; tick(6); keys = '0; tick(4);
    chk("prio_no_we", we_cnt - w0, 0);
    chk("prio_start", clr_cnt - c0, 1);
    press(0, 6); pulse_done();
    chk("prio_halted", {31'd0, run}, 0);

    // Long hold gives one event
    a0 = panel_addr; w0 = we_cnt; sw = 12'o0055;
    press(5, 1000);
    chk("hold_one_we", we_cnt - w0, 1);
    chk("hold_addr", {20'd0, panel_addr}, {20'd0, a0 + 12'd1});

    // Reset while STOPPING
    press(2, 6); press(0, 6);
    chk("stopping_run", {31'd0, run}, 1);
    rst_n = 1'b0; #1;
    chk("async_rst_run", {30'd0, run, running}, 0);
    chk("async_rst_bus", {31'd0, panel_bus}, 1);
    chk("async_rst_addr", {8'd0, panel_addr, mb_disp}, 0);
    keys[2] = 1'b1;
    tick(2); rst_n = 1'b1; tick(10);
    h0 = halt_cnt;
    pulse_done();
    chk("rst_stop_discarded", halt_cnt - h0, 0);
    chk("held_key_no_event", {31'd0, run}, 0);
    keys = '0; tick(4);
    chk("bus_never_violated", bus_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
